// File: rtl/bank_loader_fsm.sv
// Streams X_DEPTH activation words, then W_DEPTH weight words, into two banks.
// Each accepted word becomes a one-cycle active-low write strobe on the following cycle.
module bank_loader_fsm #(
    parameter int BW      = 4,
    parameter int ROW     = 8,
    parameter int X_DEPTH = 36,
    parameter int W_DEPTH = 72
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [ROW*BW-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              x_bank_wr_en_n_o,
    output logic [7:0]        x_bank_wr_addr_o,
    output logic              w_bank_wr_en_n_o,
    output logic [6:0]        w_bank_wr_addr_o,
    output logic [ROW*BW-1:0] bank_wr_data_o,
    output logic              mem_load_complete_o,
    output logic              busy_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_X = 2'd1;
    localparam logic [1:0] LOAD_W = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [7:0] X_LAST = 8'(X_DEPTH - 1);
    localparam logic [6:0] W_LAST = 7'(W_DEPTH - 1);

    logic [1:0] state;
    logic [7:0] x_cnt;
    logic [6:0] w_cnt;

    assign in_ready_o = (state == LOAD_X) || (state == LOAD_W);
    assign busy_o     = in_ready_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            x_cnt               <= '0;
            w_cnt               <= '0;
            x_bank_wr_en_n_o    <= 1'b1;
            w_bank_wr_en_n_o    <= 1'b1;
            x_bank_wr_addr_o    <= '0;
            w_bank_wr_addr_o    <= '0;
            bank_wr_data_o      <= '0;
            mem_load_complete_o <= 1'b0;
        end else begin
            x_bank_wr_en_n_o    <= 1'b1;
            w_bank_wr_en_n_o    <= 1'b1;
            // Rises the cycle after entering DONE, drops on the edge that takes a new start.
            mem_load_complete_o <= (state == DONE) && !start_i;

            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state <= LOAD_X;
                        x_cnt <= '0;
                        w_cnt <= '0;
                    end
                end
                LOAD_X: begin
                    if (in_valid_i) begin
                        x_bank_wr_en_n_o <= 1'b0;
                        x_bank_wr_addr_o <= x_cnt;
                        bank_wr_data_o   <= in_data_i;
                        x_cnt            <= x_cnt + 8'd1;
                        if (x_cnt == X_LAST)
                            state <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (in_valid_i) begin
                        w_bank_wr_en_n_o <= 1'b0;
                        w_bank_wr_addr_o <= w_cnt;
                        bank_wr_data_o   <= in_data_i;
                        w_cnt            <= w_cnt + 7'd1;
                        if (w_cnt == W_LAST)
                            state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_loader_fsm.sv
// Scoreboard bench for bank_loader_fsm: expected bank writes are queued as beats are
// driven and popped when the matching strobe appears.
module tb_bank_loader_fsm;

    localparam int XD = 36;
    localparam int WD = 72;
    localparam int NB = XD + WD;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_ready_o;
    logic        x_bank_wr_en_n_o;
    logic [7:0]  x_bank_wr_addr_o;
    logic        w_bank_wr_en_n_o;
    logic [6:0]  w_bank_wr_addr_o;
    logic [31:0] bank_wr_data_o;
    logic        mem_load_complete_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_strobe = 0;
    logic [40:0] exp_q[$];

    always #5 clk = ~clk;

    bank_loader_fsm dut (
        .clk                 (clk),
        .reset               (reset),
        .start_i             (start_i),
        .in_valid_i          (in_valid_i),
        .in_data_i           (in_data_i),
        .in_ready_o          (in_ready_o),
        .x_bank_wr_en_n_o    (x_bank_wr_en_n_o),
        .x_bank_wr_addr_o    (x_bank_wr_addr_o),
        .w_bank_wr_en_n_o    (w_bank_wr_en_n_o),
        .w_bank_wr_addr_o    (w_bank_wr_addr_o),
        .bank_wr_data_o      (bank_wr_data_o),
        .mem_load_complete_o (mem_load_complete_o),
        .busy_o              (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entry layout: {bank (0=X,1=W), addr[7:0], data[31:0]}
    always @(negedge clk) begin
        logic [40:0] obs;
        chk("dual_strobe", {63'd0, (!x_bank_wr_en_n_o && !w_bank_wr_en_n_o)}, 64'd0);
        if (!x_bank_wr_en_n_o || !w_bank_wr_en_n_o) begin
            n_strobe++;
            if (!x_bank_wr_en_n_o) obs = {1'b0, x_bank_wr_addr_o, bank_wr_data_o};
            else                   obs = {1'b1, 1'b0, w_bank_wr_addr_o, bank_wr_data_o};
            if (exp_q.size() == 0)
                chk("unexpected_strobe", {23'd0, obs}, 64'd0);
            else
                chk("bank_write", {23'd0, obs}, {23'd0, exp_q.pop_front()});
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x_en_n"}, {63'd0, x_bank_wr_en_n_o}, 64'd1);
        chk({tag, "_w_en_n"}, {63'd0, w_bank_wr_en_n_o}, 64'd1);
        chk({tag, "_x_addr"}, {56'd0, x_bank_wr_addr_o}, 64'd0);
        chk({tag, "_w_addr"}, {57'd0, w_bank_wr_addr_o}, 64'd0);
        chk({tag, "_data"},   {32'd0, bank_wr_data_o}, 64'd0);
        chk({tag, "_ready"},  {63'd0, in_ready_o}, 64'd0);
        chk({tag, "_busy"},   {63'd0, busy_o}, 64'd0);
        chk({tag, "_done"},   {63'd0, mem_load_complete_o}, 64'd0);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("start_done_low", {63'd0, mem_load_complete_o}, 64'd0);
        chk("start_busy", {63'd0, busy_o}, 64'd1);
        chk("start_ready", {63'd0, in_ready_o}, 64'd1);
    endtask

    // mid_start / rst_beat select a beat index for the event; -1 disables it.
    task automatic run_load(input bit gaps, input int mid_start, input int rst_beat);
        int beat = 0;
        int cyc = 0;
        logic [31:0] dat;
        n_strobe = 0;
        do_start();
        while (beat < NB) begin
            cyc++;
            if (gaps && (cyc % 3 == 0)) begin
                in_valid_i = 1'b0;
                in_data_i  = $urandom;
                @(posedge clk); #1;
                continue;
            end
            if (beat == 35)      dat = 32'hAAAA_AAAA;
            else if (beat == 36) dat = 32'h5555_5555;
            else                 dat = $urandom;
            in_valid_i = 1'b1;
            in_data_i  = dat;
            start_i    = (beat == mid_start);
            if (beat == rst_beat) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0; in_valid_i = 1'b0; start_i = 1'b0;
                chk_reset_vals("rst_mid");
                chk("rst_queue_empty", 64'(exp_q.size()), 64'd0);
                exp_q.delete();
                return;
            end
            if (beat < XD) exp_q.push_back({1'b0, 8'(beat), dat});
            else           exp_q.push_back({1'b1, 8'(beat - XD), dat});
            @(posedge clk); #1;
            start_i = 1'b0;
            beat++;
        end
        in_valid_i = 1'b0;
        chk("end_busy", {63'd0, busy_o}, 64'd0);
        chk("done_at_1", {63'd0, mem_load_complete_o}, 64'd0);
        @(posedge clk); #1;
        chk("done_at_2", {63'd0, mem_load_complete_o}, 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("strobe_count", 64'(n_strobe), 64'(NB));
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", {63'd0, mem_load_complete_o}, 64'd1);
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        reset = 1'b0;
        @(posedge clk); #1;

        run_load(1'b0, -1, -1);   // full back-to-back load with boundary data
        run_load(1'b1, 50, -1);   // reload from DONE, gaps, ignored mid-load start
        run_load(1'b0, -1, 60);   // reset mid-load
        @(posedge clk); #1;
        chk_reset_vals("post_rst");
        run_load(1'b0, -1, -1);   // reload from IDLE after abort

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
